// File: rtl/uart_buffered_if.sv
// CPU-side bus bundle for uart_buffered: FIFO handshakes, register write strobe, status flags.
// parity_err exists only when UART_PARITY_EN is defined.
interface uart_buffered_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_wr;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_full;
    logic                 tx_busy;
    logic                 rx_rd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_empty;
    logic [7:0]           access_addr;
    logic                 reg_w_en;
    logic                 overrun_err;
    logic                 frame_err;
    logic                 int_req;
`ifdef UART_PARITY_EN
    logic                 parity_err;

    modport master (
        output tx_wr, tx_data, rx_rd, access_addr, reg_w_en,
        input  tx_full, tx_busy, rx_data, rx_empty,
        input  overrun_err, frame_err, int_req, parity_err
    );
    modport slave (
        input  tx_wr, tx_data, rx_rd, access_addr, reg_w_en,
        output tx_full, tx_busy, rx_data, rx_empty,
        output overrun_err, frame_err, int_req, parity_err
    );
`else
    modport master (
        output tx_wr, tx_data, rx_rd, access_addr, reg_w_en,
        input  tx_full, tx_busy, rx_data, rx_empty,
        input  overrun_err, frame_err, int_req
    );
    modport slave (
        input  tx_wr, tx_data, rx_rd, access_addr, reg_w_en,
        output tx_full, tx_busy, rx_data, rx_empty,
        output overrun_err, frame_err, int_req
    );
`endif
endinterface

// File: rtl/uart_buffered.sv
// Buffered UART: TX/RX FIFOs, serializer/deserializer FSMs, sticky errors, acked IRQ.
// Define UART_PARITY_EN to add an even-parity bit and the parity_err flag.
module uart_buffered #(
    parameter int         CLK_HZ       = 50_000_000,
    parameter int         BAUD         = 115200,
    parameter int         DATA_BITS    = 8,
    parameter int         TX_DEPTH     = 4,
    parameter int         RX_DEPTH     = 8,
    parameter logic [7:0] INT_ACK_ADDR = 8'd252
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           tx,
    input  logic           rx,
    uart_buffered_if.slave bus
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TCW = TAW + 1;
    localparam int RCW = RAW + 1;

    localparam logic [CW-1:0]  LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]  MID   = CW'(DIV / 2 - 1);
    localparam logic [BW-1:0]  BLAST = BW'(DATA_BITS - 1);
    localparam logic [TCW-1:0] TFULL = TCW'(TX_DEPTH);
    localparam logic [RCW-1:0] RFULL = RCW'(RX_DEPTH);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} st_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_e;
`endif

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] txm_q [TX_DEPTH];
    logic [TAW-1:0]       txw_q, txr_q;
    logic [TCW-1:0]       txc_q, txc_d;
    logic                 tx_empty, tx_push, tx_pop;
    st_e                  tst_q;

    assign tx_empty    = (txc_q == '0);
    assign bus.tx_full = (txc_q == TFULL);
    assign tx_pop      = (tst_q == S_IDLE) && !tx_empty;
    assign tx_push     = bus.tx_wr && (!bus.tx_full || tx_pop);
    assign txc_d       = txc_q + TCW'(tx_push) - TCW'(tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) txm_q[txw_q] <= bus.tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txw_q <= '0;
            txr_q <= '0;
            txc_q <= '0;
        end else begin
            if (tx_push) txw_q <= txw_q + 1'b1;
            if (tx_pop)  txr_q <= txr_q + 1'b1;
            txc_q <= txc_d;
        end
    end

    // ---------------- TX serializer ----------------
    logic [CW-1:0]        tcnt_q;
    logic [BW-1:0]        tbit_q;
    logic [DATA_BITS-1:0] tsh_q;
    logic                 tx_q;
`ifdef UART_PARITY_EN
    logic                 tpar_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tst_q  <= S_IDLE;
            tcnt_q <= '0;
            tbit_q <= '0;
            tsh_q  <= '0;
            tx_q   <= 1'b1;
`ifdef UART_PARITY_EN
            tpar_q <= 1'b0;
`endif
        end else begin
            unique case (tst_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (!tx_empty) begin
                        tst_q  <= S_START;
                        tx_q   <= 1'b0;
                        tsh_q  <= txm_q[txr_q];
                        tcnt_q <= '0;
`ifdef UART_PARITY_EN
                        tpar_q <= ^txm_q[txr_q];
`endif
                    end
                end
                S_START: begin
                    if (tcnt_q == LAST) begin
                        tcnt_q <= '0;
                        tbit_q <= '0;
                        tst_q  <= S_DATA;
                        tx_q   <= tsh_q[0];
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tcnt_q == LAST) begin
                        tcnt_q <= '0;
                        if (tbit_q == BLAST) begin
`ifdef UART_PARITY_EN
                            tst_q <= S_PAR;
                            tx_q  <= tpar_q;
`else
                            tst_q <= S_STOP;
                            tx_q  <= 1'b1;
`endif
                        end else begin
                            tbit_q <= tbit_q + 1'b1;
                            tsh_q  <= tsh_q >> 1;
                            tx_q   <= tsh_q[1];
                        end
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PAR: begin
                    if (tcnt_q == LAST) begin
                        tcnt_q <= '0;
                        tst_q  <= S_STOP;
                        tx_q   <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tcnt_q == LAST) begin
                        tcnt_q <= '0;
                        tst_q  <= S_IDLE;
                        tx_q   <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                default: tst_q <= S_IDLE;
            endcase
        end
    end

    assign tx          = tx_q;
    assign bus.tx_busy = !tx_empty || (tst_q != S_IDLE);

    // ---------------- RX synchroniser and deserializer ----------------
    logic                 rs1_q, rs2_q, rs3_q;
    st_e                  rst_q;
    logic [CW-1:0]        rcnt_q;
    logic [BW-1:0]        rbit_q;
    logic [DATA_BITS-1:0] rsh_q;
`ifdef UART_PARITY_EN
    logic                 rpb_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q <= 1'b1;
            rs2_q <= 1'b1;
            rs3_q <= 1'b1;
        end else begin
            rs1_q <= rx;
            rs2_q <= rs1_q;
            rs3_q <= rs2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_q  <= S_IDLE;
            rcnt_q <= '0;
            rbit_q <= '0;
            rsh_q  <= '0;
`ifdef UART_PARITY_EN
            rpb_q  <= 1'b0;
`endif
        end else begin
            unique case (rst_q)
                S_IDLE: begin
                    rcnt_q <= '0;
                    if (rs3_q && !rs2_q) rst_q <= S_START;
                end
                S_START: begin
                    // Mid-start resample rejects short low glitches
                    if (rcnt_q == MID) begin
                        rcnt_q <= '0;
                        rbit_q <= '0;
                        rst_q  <= rs2_q ? S_IDLE : S_DATA;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rcnt_q == LAST) begin
                        rcnt_q <= '0;
                        rsh_q  <= {rs2_q, rsh_q[DATA_BITS-1:1]};
                        if (rbit_q == BLAST) begin
`ifdef UART_PARITY_EN
                            rst_q <= S_PAR;
`else
                            rst_q <= S_STOP;
`endif
                        end else begin
                            rbit_q <= rbit_q + 1'b1;
                        end
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PAR: begin
                    if (rcnt_q == LAST) begin
                        rcnt_q <= '0;
                        rpb_q  <= rs2_q ^ (^rsh_q);
                        rst_q  <= S_STOP;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (rcnt_q == LAST) begin
                        rcnt_q <= '0;
                        rst_q  <= S_IDLE;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
                default: rst_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] rxm_q [RX_DEPTH];
    logic [RAW-1:0]       rxw_q, rxr_q;
    logic [RCW-1:0]       rxc_q, rxc_d;
    logic                 rx_full, rx_push, rx_pop;
    logic                 stop_hit, stop_ok, ovr_set, fe_set;

    assign rx_full      = (rxc_q == RFULL);
    assign bus.rx_empty = (rxc_q == '0);
    assign rx_pop       = bus.rx_rd && !bus.rx_empty;
    assign stop_hit     = (rst_q == S_STOP) && (rcnt_q == LAST);
    assign stop_ok      = stop_hit && rs2_q;
    assign rx_push      = stop_ok && (!rx_full || rx_pop);
    assign ovr_set      = stop_ok && rx_full && !rx_pop;
    assign fe_set       = stop_hit && !rs2_q;
    assign rxc_d        = rxc_q + RCW'(rx_push) - RCW'(rx_pop);
    assign bus.rx_data  = bus.rx_empty ? '0 : rxm_q[rxr_q];

    always_ff @(posedge clk) begin
        if (rx_push) rxm_q[rxw_q] <= rsh_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxw_q <= '0;
            rxr_q <= '0;
            rxc_q <= '0;
        end else begin
            if (rx_push) rxw_q <= rxw_q + 1'b1;
            if (rx_pop)  rxr_q <= rxr_q + 1'b1;
            rxc_q <= rxc_d;
        end
    end

    // ---------------- Flags and interrupt ----------------
    logic ack, irq_set;
    logic int_q, int_d;
    logic ovr_q, ovr_d;
    logic fe_q, fe_d;

    assign ack = bus.reg_w_en && (bus.access_addr == INT_ACK_ADDR);

`ifdef UART_PARITY_EN
    logic par_set, par_q, par_d;

    assign par_set        = stop_ok && rpb_q;
    assign par_d          = par_set | (par_q & ~ack);
    assign irq_set        = rx_push | ovr_set | fe_set | par_set;
    assign bus.parity_err = par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end
`else
    assign irq_set = rx_push | ovr_set | fe_set;
`endif

    // A new event in the ack cycle keeps its flag set
    assign int_d = irq_set | (int_q & ~ack);
    assign ovr_d = ovr_set | (ovr_q & ~ack);
    assign fe_d  = fe_set  | (fe_q  & ~ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_q <= 1'b0;
            ovr_q <= 1'b0;
            fe_q  <= 1'b0;
        end else begin
            int_q <= int_d;
            ovr_q <= ovr_d;
            fe_q  <= fe_d;
        end
    end

    assign bus.int_req     = int_q;
    assign bus.overrun_err = ovr_q;
    assign bus.frame_err   = fe_q;

endmodule
